receiving_device: RTL and testbench
===================================

# receiving_device

Receiving end of the touch-counter link: deserializes frames produced by the transmitting device's serial transmitter and buffers the recovered words in an internal FIFO until the consumer pops them. Sits on the far side of the link, with a display or host logic reading words out. Detects framing errors, parity errors (optional) and overflow.

## Interface
- WORD_SIZE, 4, data bits per frame; matches the transmitting side.
- BIT_PERIOD, 10, CLOCK_50 cycles per serial bit; even, ≥4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two.

- CLOCK_50  in  1  system clock; all state rises on its edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx  in  1  serial input, idle high, asynchronous to CLOCK_50.
- read_enable  in  1  pop the head word; ignored when empty.
- data_out  out  WORD_SIZE  FIFO head (show-ahead); 0 when empty.
- empty  out  1  FIFO holds no words.
- full  out  1  FIFO holds FIFO_DEPTH words.
- busy  out  1  receiver FSM not in IDLE.
- frame_error  out  1  sticky; stop bit sampled low.
- parity_error  out  1  sticky; parity mismatch (see Configuration).
- overflow  out  1  sticky; valid word dropped because FIFO full.

## Operation
- rx passes a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP. Cycle counter cnt and bit index idx, widths sized from BIT_PERIOD and WORD_SIZE.
- IDLE: on rxs==0 go START, cnt=0.
- START: when cnt==BIT_PERIOD/2-1 sample rxs; 1 → false start, return IDLE, no flag; 0 → DATA, cnt=0, idx=0.
- DATA: when cnt==BIT_PERIOD-1 sample rxs into shift register, LSB first; after bit WORD_SIZE-1 go PARITY (if enabled) else STOP.
- PARITY: sample after BIT_PERIOD cycles, go STOP.
- STOP: sample after BIT_PERIOD cycles, then IDLE. Stop=0 → set frame_error, discard word. Parity mismatch → set parity_error, discard. Otherwise push word; if full and no pop that cycle → discard, set overflow.
- FIFO: push and pop in the same cycle always both succeed (including full and empty-with-push cases: when empty, pop is ignored, push proceeds). Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on reset.

## Timing
- Reset values: data_out=0, empty=1, full=0, busy=0, all error flags 0, FSM IDLE, pointers 0.
- rx→rxs latency 2 cycles; busy rises 1 cycle after rxs falls.
- Data bit k sampled BIT_PERIOD/2 + (k+1)·BIT_PERIOD cycles after START entry (mid-bit).
- Push happens on the stop-sample edge; empty falls and data_out shows the word the following cycle.
- Pop: data_out advances the cycle after read_enable is high.
- Error flags rise the cycle after the stop-sample edge.
- Back-to-back frames: a start edge one bit after the stop sample is accepted.
- reset mid-frame: partial word discarded, FIFO emptied, FSM IDLE immediately.

## Configuration
- RX_PARITY_EN defined: frame = start, WORD_SIZE data, even parity bit, stop; PARITY state active, parity_error functional.
- RX_PARITY_EN undefined: frame = start, data, stop; PARITY state never entered, parity_error tied 0.

## Structure
- Shared package: WORD_SIZE default, FSM state encoding (IDLE/START/DATA/PARITY/STOP), frame bit-count constant.
- Sub-module rx_fifo (synchronous, show-ahead, full/empty, simultaneous push/pop); deserializer FSM and synchronizer stay in the top.

## Test plan
- Frame 0xA (bits 0,1,0,1 LSB first) at BIT_PERIOD=10, stop=1 → empty falls, data_out=0xA, no flags.
- 0.3-bit low glitch on idle rx → FSM returns IDLE, no push, no flags.
- Frame 0x5 with stop=0 → frame_error=1, empty stays 1.
- Five valid frames 0x1–0x5, no reads → full=1 after 4th, overflow=1, pops yield 0x1..0x4, then empty=1.
- Full FIFO, 5th frame stop-sample coincides with read_enable → no overflow, pops yield 0x2..0x5.
- With RX_PARITY_EN: 0x3 with parity 1 → parity_error=1, word dropped; parity 0 → 0x3 buffered. Reset mid-DATA → all outputs at reset values.

Source files
------------

// File: rtl/receiving_device_pkg.sv
// Shared constants and FSM encoding for the touch-counter link receiver.
// Optional feature macro: RX_PARITY_EN (adds an even-parity bit to each frame).
package receiving_device_pkg;

    localparam int unsigned RX_WORD_SIZE = 4;

`ifdef RX_PARITY_EN
    localparam int unsigned RX_PARITY_BITS = 1;
`else
    localparam int unsigned RX_PARITY_BITS = 0;
`endif

    // start + data + optional parity + stop
    localparam int unsigned RX_FRAME_BITS = 2 + RX_WORD_SIZE + RX_PARITY_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/receiving_device_rx_fifo.sv
// Receive FIFO: synchronous, show-ahead head register, simultaneous push/pop.
module rx_fifo
    import receiving_device_pkg::*;
#(
    parameter int unsigned DATA_W = RX_WORD_SIZE,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_n, wr_q, wr_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [DATA_W-1:0] head_n;
    logic              do_push, do_pop;

    // Next pointers, occupancy and the head word visible after this edge
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_n    = do_pop  ? PTR_W'(rd_q + PTR_W'(1)) : rd_q;
        wr_n    = do_push ? PTR_W'(wr_q + PTR_W'(1)) : wr_q;
        count_n = count_q;
        case ({do_push, do_pop})
            2'b10:   count_n = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_n = CNT_W'(count_q - CNT_W'(1));
            default: count_n = count_q;
        endcase
        head_n = '0;
        if (count_n != '0) begin
            if (do_push && (wr_q == rd_n)) begin
                head_n = push_data;
            end else begin
                head_n = mem[rd_n];
            end
        end
    end

    // Storage, pointers and registered status
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            data_out <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_q] <= push_data;
            end
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            count_q  <= count_n;
            data_out <= head_n;
            empty    <= (count_n == '0);
            full     <= (count_n == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/receiving_device.sv
// Touch-counter link receiver: synchronizes rx, deserializes frames and
// buffers words in rx_fifo. Optional feature macro: RX_PARITY_EN.
module receiving_device
    import receiving_device_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = RX_WORD_SIZE,
    parameter int unsigned BIT_PERIOD = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read_enable,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 busy,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overflow
);

    localparam int unsigned CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    rx_state_t            state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [WORD_SIZE-1:0] sh_q, sh_n;
    logic                 rx_meta, rxs;
    logic                 push_c;
    logic                 frame_err_set_c;
    logic                 overflow_set_c;
    logic                 bit_end_c;
    logic                 fifo_full;

`ifdef RX_PARITY_EN
    logic par_q, par_n;
    logic parity_bad_c;
    logic par_err_set_c;
    logic parity_err_q;
`endif

    // Two-flop synchronizer; idle-high reset value avoids a false start
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // FSM state, counters, shift register and sticky flags
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
`ifdef RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            sh_q    <= sh_n;
            busy    <= (state_n != IDLE);
            if (frame_err_set_c) begin
                frame_error <= 1'b1;
            end
            if (overflow_set_c) begin
                overflow <= 1'b1;
            end
`ifdef RX_PARITY_EN
            par_q <= par_n;
            if (par_err_set_c) begin
                parity_err_q <= 1'b1;
            end
`endif
        end
    end

    // Next-state and per-frame decisions
    always_comb begin
        state_n         = state_q;
        cnt_n           = CNT_W'(cnt_q + CNT_W'(1));
        idx_n           = idx_q;
        sh_n            = sh_q;
        push_c          = 1'b0;
        frame_err_set_c = 1'b0;
        bit_end_c       = (cnt_q == CNT_W'(BIT_PERIOD - 1));
`ifdef RX_PARITY_EN
        par_n           = par_q;
        parity_bad_c    = ((^sh_q) != par_q);
        par_err_set_c   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(BIT_PERIOD / 2 - 1)) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_n = '0;
                    sh_n  = {rxs, sh_q[WORD_SIZE-1:1]};
                    if (idx_q == IDX_W'(WORD_SIZE - 1)) begin
`ifdef RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = IDX_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    cnt_n   = '0;
                    state_n = STOP;
`ifdef RX_PARITY_EN
                    par_n   = rxs;
`endif
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rxs) begin
                        frame_err_set_c = 1'b1;
`ifdef RX_PARITY_EN
                    end else if (parity_bad_c) begin
                        par_err_set_c = 1'b1;
`endif
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        overflow_set_c = push_c && fifo_full && !read_enable;
    end

`ifdef RX_PARITY_EN
    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

    assign full = fifo_full;

    // Receive buffer
    rx_fifo #(
        .DATA_W (WORD_SIZE),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .push      (push_c),
        .push_data (sh_q),
        .pop       (read_enable),
        .data_out  (data_out),
        .empty     (empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_receiving_device.sv
// Directed bench for receiving_device (WORD_SIZE=4, BIT_PERIOD=10, FIFO_DEPTH=4).
// Build with RX_PARITY_EN defined to include the parity cases.
module tb_receiving_device;
    import receiving_device_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned BP = 10;
    // Cycle (counted in negedges from the start-bit drive) whose following
    // posedge is the stop-sample edge.
    localparam int STOP_CYC = 2 + BP / 2 + (RX_FRAME_BITS - 1) * BP;

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic         rx;
    logic         read_enable;
    logic [W-1:0] data_out;
    logic         empty, full, busy, frame_error, parity_error, overflow;

    int checks   = 0;
    int failures = 0;

    receiving_device #(
        .WORD_SIZE  (W),
        .BIT_PERIOD (BP),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .rx           (rx),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .busy         (busy),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overflow     (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        rx = 1'b1;
        read_enable = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    // Drive one frame plus two idle bit times; pulse read_enable at cycle pop_at
    task automatic send_frame(input logic [W-1:0] d, input logic stop_b,
                              input logic par_b, input int pop_at);
        logic [15:0] bits;
        int n;
        n = int'(RX_FRAME_BITS);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < int'(W); i++) bits[1 + i] = d[i];
`ifdef RX_PARITY_EN
        bits[1 + W] = par_b;
        bits[2 + W] = stop_b;
`else
        bits[1 + W] = stop_b;
        if (par_b) bits[15] = 1'b1;
`endif
        for (int c = 0; c < (n + 2) * int'(BP); c++) begin
            rx = (c < n * int'(BP)) ? bits[c / int'(BP)] : 1'b1;
            read_enable = (c == pop_at);
            @(negedge CLOCK_50);
        end
        rx = 1'b1;
        read_enable = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [W-1:0] exp);
        check(tag, 32'(data_out), 32'(exp));
        read_enable = 1'b1;
        @(negedge CLOCK_50);
        read_enable = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        read_enable = 1'b0;
        idle(3);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ferr", 32'(frame_error), 32'h0);
        check("rst_perr", 32'(parity_error), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        idle(2);

        // Valid frame 0xA
        send_frame(4'hA, 1'b1, 1'b0, -1);
        check("a_empty", 32'(empty), 32'h0);
        check("a_data", 32'(data_out), 32'hA);
        check("a_ferr", 32'(frame_error), 32'h0);
        check("a_ovf", 32'(overflow), 32'h0);
        pop_expect("a_pop", 4'hA);
        check("a_empty_after", 32'(empty), 32'h1);
        check("a_data_after", 32'(data_out), 32'h0);

        // 3-cycle glitch: busy goes high, then a false start returns to idle
        rx = 1'b0;
        idle(3);
        check("glitch_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        idle(20);
        check("glitch_idle", 32'(busy), 32'h0);
        check("glitch_empty", 32'(empty), 32'h1);
        check("glitch_ferr", 32'(frame_error), 32'h0);

        // Bad stop bit
        send_frame(4'h5, 1'b0, 1'b0, -1);
        check("ferr_flag", 32'(frame_error), 32'h1);
        check("ferr_empty", 32'(empty), 32'h1);
        idle(10);
        check("ferr_sticky", 32'(frame_error), 32'h1);

        // Overflow: five frames, no reads
        do_reset();
        check("ferr_cleared", 32'(frame_error), 32'h0);
        for (int k = 1; k <= 4; k++) send_frame(W'(k), 1'b1, 1'b0, -1);
        check("ovf_full4", 32'(full), 32'h1);
        check("ovf_flag4", 32'(overflow), 32'h0);
        send_frame(4'h5, 1'b1, 1'b0, -1);
        check("ovf_flag5", 32'(overflow), 32'h1);
        for (int k = 1; k <= 4; k++) pop_expect("ovf_pop", W'(k));
        check("ovf_empty", 32'(empty), 32'h1);
        check("ovf_full0", 32'(full), 32'h0);

        // Full FIFO with a pop on the stop-sample edge of the fifth frame
        do_reset();
        for (int k = 1; k <= 4; k++) send_frame(W'(k), 1'b1, 1'b0, -1);
        send_frame(4'h5, 1'b1, 1'b0, STOP_CYC);
        check("coinc_ovf", 32'(overflow), 32'h0);
        check("coinc_full", 32'(full), 32'h1);
        for (int k = 2; k <= 5; k++) pop_expect("coinc_pop", W'(k));
        check("coinc_empty", 32'(empty), 32'h1);

`ifdef RX_PARITY_EN
        // Even parity: 0x3 needs parity bit 0
        do_reset();
        send_frame(4'h3, 1'b1, 1'b1, -1);
        check("par_bad_flag", 32'(parity_error), 32'h1);
        check("par_bad_empty", 32'(empty), 32'h1);
        do_reset();
        send_frame(4'h3, 1'b1, 1'b0, -1);
        check("par_ok_flag", 32'(parity_error), 32'h0);
        check("par_ok_data", 32'(data_out), 32'h3);
`endif

        // Reset in the middle of a frame with a word already buffered
        do_reset();
        send_frame(4'h6, 1'b1, 1'b0, -1);
        check("mid_pre_data", 32'(data_out), 32'h6);
        rx = 1'b0;
        idle(BP);
        rx = 1'b1;
        idle(BP);
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_empty", 32'(empty), 32'h1);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_full", 32'(full), 32'h0);
        check("mid_rst_ferr", 32'(frame_error), 32'h0);
        check("mid_rst_perr", 32'(parity_error), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        idle(2);
        reset = 1'b0;
        idle(8 * BP);
        check("mid_post_busy", 32'(busy), 32'h0);
        check("mid_post_empty", 32'(empty), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
